// File: rtl/matrix_pkg.sv
// ============================================================================
// Module      : matrix_pkg
// Description : Shared matrix geometry constants and reader FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int MAT_ROWS   = 10;
  localparam int MAT_COLS   = 10;
  localparam int MAT_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : matrix_pkg

`default_nettype wire

// File: rtl/stream_fifo2.sv
// ============================================================================
// Module      : stream_fifo2
// Description : Two-entry FIFO holding packed {data,row,col,last} stream words.
//               Push and pop in the same cycle are allowed; flush empties it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic [1:0]   o_count,
  output logic         o_empty,
  output logic         o_full
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  // A push into a full FIFO is only accepted when the head leaves that cycle.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy; flush resets pointers but keeps old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule : stream_fifo2

`default_nettype wire

// File: rtl/matrix_stream_reader.sv
// ============================================================================
// Module      : matrix_stream_reader
// Description : Walks a ROWS x COLS matrix store in row-major order and emits
//               each entry on a valid/ready stream tagged with row, col, last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_stream_reader
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = MAT_ROWS,
  parameter int COLS       = MAT_COLS,
  parameter int ADDR_W     = MAT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_en_ReadMat,
  output logic                  o_en_WriteMat,
  output logic [ADDR_W-1:0]     o_rowAddr,
  output logic [ADDR_W-1:0]     o_colAddr,
  input  logic [DATA_WIDTH-1:0] i_readData,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [ADDR_W-1:0]     o_m_row,
  output logic [ADDR_W-1:0]     o_m_col,
  output logic                  o_m_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int ENTRY_W = DATA_WIDTH + 2 * ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_row;
  logic [ADDR_W-1:0]   r_col;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_tag_row;
  logic [ADDR_W-1:0]   r_tag_col;
  logic                r_tag_last;

  logic                w_issue;
  logic                w_accept_start;
  logic                w_at_end;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic [1:0]          w_count;
  logic                w_empty;
  logic                w_full;
  logic [ENTRY_W-1:0]  w_wdata;
  logic [ENTRY_W-1:0]  w_head;

  assign w_pop          = !w_empty && i_m_ready;
  assign w_at_end       = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_accept_start = (r_state == IDLE) && i_start && !i_abort;

  // Occupancy after this edge: buffered words, plus the read landing now,
  // minus the word the consumer takes now. A new read is safe while this is < 2.
  assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Next-state and issue decision; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if ((w_occ < 3'd2) && !w_full) begin
          w_issue = 1'b1;
          if (w_at_end) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_occ == 3'd0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (i_abort) begin
      w_state_nxt = IDLE;
      w_issue     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Row/col walk counters; they park on the last entry so the address holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept_start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_issue && !w_at_end) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Track the single outstanding read and the coordinates it was issued for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_col  <= '0;
      r_tag_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_row  <= r_row;
        r_tag_col  <= r_col;
        r_tag_last <= w_at_end;
      end
    end
  end

  assign w_wdata = {i_readData, r_tag_row, r_tag_col, r_tag_last};

  stream_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_abort),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_en_ReadMat  = w_issue;
  assign o_en_WriteMat = 1'b0;
  assign o_rowAddr     = r_row;
  assign o_colAddr     = r_col;
  assign o_m_valid     = !w_empty;
  assign o_m_data      = w_head[ENTRY_W-1 -: DATA_WIDTH];
  assign o_m_row       = w_head[2*ADDR_W -: ADDR_W];
  assign o_m_col       = w_head[ADDR_W -: ADDR_W];
  assign o_m_last      = w_head[0];
  assign o_busy        = (r_state == ISSUE) || (r_state == DRAIN);
  assign o_done        = (r_state == DONE);

endmodule : matrix_stream_reader

`default_nettype wire

// File: tb/tb_matrix_stream_reader.sv
// ============================================================================
// Module      : tb_matrix_stream_reader
// Description : Self-checking bench: matrix store model, per-cycle stream
//               model and directed scenarios for the matrix stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_m_ready = 1'b0;
  logic [7:0] readData = 8'd0;
  logic       o_en_ReadMat, o_en_WriteMat, o_m_valid, o_m_last, o_busy, o_done;
  logic [3:0] o_rowAddr, o_colAddr, o_m_row, o_m_col;
  logic [7:0] o_m_data;

  int checks = 0;
  int failures = 0;

  // Model state: expected busy/done for the current cycle, reads issued and
  // words accepted in the current walk.
  bit  m_busy = 1'b0;
  bit  m_done = 1'b0;
  int  m_issued = 0;
  int  m_hs = 0;
  bit  prev_stall = 1'b0;
  logic [16:0] prev_word = '0;

  matrix_stream_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .o_en_ReadMat  (o_en_ReadMat),
    .o_en_WriteMat (o_en_WriteMat),
    .o_rowAddr     (o_rowAddr),
    .o_colAddr     (o_colAddr),
    .i_readData    (readData),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (i_m_ready),
    .o_m_data      (o_m_data),
    .o_m_row       (o_m_row),
    .o_m_col       (o_m_col),
    .o_m_last      (o_m_last),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  // Matrix store preloaded with value = 10*row + col, one-cycle read latency.
  always @(posedge clk) begin
    if (o_en_ReadMat) readData <= 8'(10 * int'(o_rowAddr) + int'(o_colAddr));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the row-major walk model.
  always @(negedge clk) begin
    bit hs;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_issued = 0; m_hs = 0; prev_stall = 1'b0;
    end else begin
      hs = o_m_valid && i_m_ready;
      chk("en_WriteMat", o_en_WriteMat, 0);
      chk("busy", o_busy, m_busy);
      chk("done", o_done, m_done);
      if (!m_busy && !m_done) begin
        chk("idle_valid", o_m_valid, 0);
        chk("idle_en", o_en_ReadMat, 0);
      end
      if (o_en_ReadMat) begin
        chk("rd_row", o_rowAddr, m_issued / 10);
        chk("rd_col", o_colAddr, m_issued % 10);
        chk("rd_room", ((m_issued - m_hs) + 1 - int'(hs)) <= 2, 1);
        m_issued++;
      end
      if (o_m_valid) begin
        chk("m_row", o_m_row, m_hs / 10);
        chk("m_col", o_m_col, m_hs % 10);
        chk("m_data", o_m_data, 10 * (m_hs / 10) + (m_hs % 10));
        chk("m_last", o_m_last, m_hs == 99);
        if (prev_stall) chk("stable", {o_m_data, o_m_row, o_m_col, o_m_last}, prev_word);
      end
      prev_stall = o_m_valid && !i_m_ready;
      prev_word  = {o_m_data, o_m_row, o_m_col, o_m_last};
      if (hs) m_hs++;
      if (i_abort) begin
        m_busy = 1'b0; m_done = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (i_start) begin
          m_busy = 1'b1; m_issued = 0; m_hs = 0; prev_stall = 1'b0;
        end
      end else if (hs && m_hs == 100) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit toggle);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (o_done) begin got = 1'b1; break; end
      if (toggle) i_m_ready = ~i_m_ready;
      tick();
    end
    chk("done_seen", got, 1);
    i_m_ready = 1'b1;
    tick();
  endtask

  task automatic wait_word(input int d);
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (o_m_valid && o_m_data == 8'(d)) begin got = 1'b1; break; end
      tick();
    end
    chk("word_seen", got, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {o_en_ReadMat, o_en_WriteMat, o_rowAddr, o_colAddr, o_m_valid,
                         o_m_data, o_m_row, o_m_col, o_m_last, o_busy, o_done}, 0);
  endtask

  initial begin
    int n, first_valid, lasts, last_data;
    // Reset state.
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(); tick();

    // 1: full walk with m_ready held high; latency pinned by literals.
    i_m_ready = 1'b1;
    pulse_start();
    chk("busy_after_start", o_busy, 1);
    n = 0; first_valid = -1; lasts = 0; last_data = -1;
    for (int i = 0; i < 300; i++) begin
      if (o_done) break;
      tick(); n++;
      if (o_m_valid && first_valid < 0) first_valid = n;
      if (o_m_valid && o_m_last) begin lasts++; last_data = o_m_data; end
    end
    chk("first_valid_lat", first_valid, 2);
    chk("done_lat", n, 102);
    chk("words_t1", m_hs, 100);
    chk("last_count", lasts, 1);
    chk("last_data", last_data, 99);
    tick();
    chk("done_one_cycle", o_done, 0);

    // 2: m_ready toggling.
    i_m_ready = 1'b0;
    pulse_start();
    wait_done(500, 1'b1);
    chk("words_t2", m_hs, 100);

    // 3: m_ready low for 20 cycles: only two reads, head holds [0,0].
    i_m_ready = 1'b0;
    pulse_start();
    repeat (20) tick();
    chk("stall_reads", m_issued, 2);
    chk("stall_valid", o_m_valid, 1);
    chk("stall_data", o_m_data, 0);
    i_m_ready = 1'b1;
    chk("release_data0", o_m_data, 0);
    tick();
    chk("resume_row", o_m_row, 0);
    chk("resume_col", o_m_col, 1);
    wait_done(300, 1'b0);

    // 4: abort at word [3,3], then a clean restart from [0,0].
    pulse_start();
    wait_word(33);
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    chk("abort_valid", o_m_valid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    repeat (5) tick();
    pulse_start();
    wait_word(0);
    chk("restart_row", o_m_row, 0);
    chk("restart_col", o_m_col, 0);
    wait_done(300, 1'b0);

    // 5: a second start mid-walk is ignored.
    pulse_start();
    repeat (30) tick();
    pulse_start();
    wait_done(300, 1'b0);
    chk("words_t5", m_hs, 100);

    // 6: asynchronous reset at word [5,7].
    pulse_start();
    wait_word(57);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_rst");
    pulse_start();
    wait_done(300, 1'b0);
    chk("words_t6", m_hs, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule : tb_matrix_stream_reader

`default_nettype wire
